// File: rtl/instruction_issue.sv
// Instruction issue stage: queues 16-bit CORDIC instructions, hands one at a
// time to Fetch, waits for the core's done pulse, expands tan/tanh into two
// back-to-back operations and drops illegal opcodes.
module instruction_issue #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [15:0]              wr_packet,
  input  logic                     done,
  output logic [15:0]              InstructionPacket,
  output logic                     stall,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state, state_nxt;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_nxt;
  logic            push_ok;
  logic            pop;
  logic            take_head;
  logic            load;
  logic [15:0]     pkt_nxt;
  logic            pend;
  logic [11:0]     pend_addr;
  logic            pend_set;
  logic            pend_clr;
  logic            drop;
  logic [15:0]     head;
  logic [3:0]      head_op;

  // Opcodes 9 and 11..15 have no CORDIC mapping.
  function automatic logic op_legal(input logic [3:0] op);
    return !((op == 4'd9) || (op >= 4'd11));
  endfunction

  // tan starts as opcode 0, tanh as opcode 1; the rest pass through.
  function automatic logic [3:0] map_op(input logic [3:0] op);
    case (op)
      4'd7:    return 4'd0;
      4'd8:    return 4'd1;
      default: return op;
    endcase
  endfunction

  assign head    = mem[rd_ptr];
  assign head_op = head[15:12];
  assign push_ok = wr_en & ~full;
  assign count_nxt = count + CW'(push_ok) - CW'(pop);

  // Next-state and issue decisions; all resulting outputs are registered.
  always_comb begin
    state_nxt = state;
    take_head = 1'b0;
    pop       = 1'b0;
    load      = 1'b0;
    pkt_nxt   = InstructionPacket;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) take_head = 1'b1;
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (done) begin
          if (pend) begin
            load      = 1'b1;
            pkt_nxt   = {4'd6, pend_addr};
            pend_clr  = 1'b1;
            state_nxt = ISSUE;
          end else if (!empty) begin
            take_head = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (take_head) begin
      pop = 1'b1;
      if (op_legal(head_op)) begin
        load      = 1'b1;
        pkt_nxt   = {map_op(head_op), head[11:0]};
        pend_set  = (head_op == 4'd7) || (head_op == 4'd8);
        state_nxt = ISSUE;
      end else begin
        // Discard and look at the queue again next cycle from IDLE.
        drop      = 1'b1;
        state_nxt = IDLE;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Queue storage; pushes during reset are ignored.
  always_ff @(posedge clock) begin
    if (reset && push_ok) mem[wr_ptr] <= wr_packet;
  end

  // Queue pointers and registered status flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      empty    <= (count_nxt == '0);
      full     <= (count_nxt == DEPTH_C);
      overflow <= wr_en & full;
    end
  end

  // Issue outputs and pending second half of tan/tanh.
  always_ff @(posedge clock) begin
    if (!reset) begin
      InstructionPacket <= 16'h0000;
      stall             <= 1'b1;
      illegal           <= 1'b0;
      pend              <= 1'b0;
      pend_addr         <= 12'h000;
    end else begin
      InstructionPacket <= pkt_nxt;
      stall             <= ~load;
      illegal           <= drop;
      if (pend_set) begin
        pend      <= 1'b1;
        pend_addr <= head[11:0];
      end else if (pend_clr) begin
        pend      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_issue.sv
// Directed bench for instruction_issue (DEPTH = 8): a vector table for the
// basic, expansion and illegal-opcode flows, then hand sequences for the
// full queue, back-to-back issue and mid-operation reset.
module tb_instruction_issue;

  logic        clock;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_packet;
  logic        done;
  logic [15:0] InstructionPacket;
  logic        stall;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  instruction_issue #(.DEPTH(8)) dut (
    .clock             (clock),
    .reset             (reset),
    .wr_en             (wr_en),
    .wr_packet         (wr_packet),
    .done              (done),
    .InstructionPacket (InstructionPacket),
    .stall             (stall),
    .full              (full),
    .empty             (empty),
    .count             (count),
    .overflow          (overflow),
    .illegal           (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        w;
    logic [15:0] p;
    logic        d;
    logic [15:0] e_pkt;
    logic        e_stall;
    logic        e_empty;
    logic        e_full;
    logic [3:0]  e_count;
    logic        e_ov;
    logic        e_il;
  } vec_t;

  vec_t vecs [27];

  function automatic vec_t mk(input logic w, input logic [15:0] p, input logic d,
                              input logic [15:0] ep, input logic es, input logic ee,
                              input logic ef, input logic [3:0] ec, input logic eo,
                              input logic ei);
    vec_t v;
    v.w = w; v.p = p; v.d = d; v.e_pkt = ep; v.e_stall = es; v.e_empty = ee;
    v.e_full = ef; v.e_count = ec; v.e_ov = eo; v.e_il = ei;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] ep, input logic es,
                       input logic ee, input logic ef, input logic [3:0] ec,
                       input logic eo, input logic ei);
    logic [24:0] act, exp;
    act = {InstructionPacket, stall, empty, full, count, overflow, illegal};
    exp = {ep, es, ee, ef, ec, eo, ei};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got pkt=%h stall=%b empty=%b full=%b count=%0d ov=%b il=%b, want pkt=%h stall=%b empty=%b full=%b count=%0d ov=%b il=%b",
               name, InstructionPacket, stall, empty, full, count, overflow, illegal,
               ep, es, ee, ef, ec, eo, ei);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic w, input logic [15:0] p, input logic d);
    wr_en = w; wr_packet = p; done = d;
  endtask

  initial begin
    // plain op, done ignored in ISSUE, tan, illegal then legal, tanh, opcode 10
    vecs[0]  = mk(1'b1, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 16'h0000, 1'b0, 16'h0005, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 16'h0000, 1'b0, 16'h0005, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 16'h0000, 1'b0, 16'h0005, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 16'h0000, 1'b0, 16'h0005, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 16'h7123, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 16'h0000, 1'b0, 16'h0123, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 16'h0000, 1'b1, 16'h0123, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 16'h0000, 1'b1, 16'h6123, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 16'h0000, 1'b0, 16'h6123, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 16'h0000, 1'b1, 16'h6123, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[12] = mk(1'b1, 16'h9ABC, 1'b0, 16'h6123, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
    vecs[13] = mk(1'b1, 16'h2010, 1'b0, 16'h6123, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1);
    vecs[14] = mk(1'b0, 16'h0000, 1'b0, 16'h2010, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 16'h0000, 1'b0, 16'h2010, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[16] = mk(1'b0, 16'h0000, 1'b1, 16'h2010, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[17] = mk(1'b1, 16'h8345, 1'b0, 16'h2010, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
    vecs[18] = mk(1'b0, 16'h0000, 1'b0, 16'h1345, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[19] = mk(1'b0, 16'h0000, 1'b0, 16'h1345, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[20] = mk(1'b0, 16'h0000, 1'b1, 16'h6345, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[21] = mk(1'b0, 16'h0000, 1'b0, 16'h6345, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[22] = mk(1'b0, 16'h0000, 1'b1, 16'h6345, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[23] = mk(1'b1, 16'hA111, 1'b0, 16'h6345, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
    vecs[24] = mk(1'b0, 16'h0000, 1'b0, 16'hA111, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[25] = mk(1'b0, 16'h0000, 1'b0, 16'hA111, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[26] = mk(1'b0, 16'h0000, 1'b1, 16'hA111, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

    reset = 1'b0;
    drive(1'b0, 16'h0000, 1'b0);
    repeat (2) step();
    check("reset_state", 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].w, vecs[i].p, vecs[i].d);
      step();
      check($sformatf("vec%0d", i), vecs[i].e_pkt, vecs[i].e_stall, vecs[i].e_empty,
            vecs[i].e_full, vecs[i].e_count, vecs[i].e_ov, vecs[i].e_il);
    end

    // Fill the queue while the core is busy, ninth push overflows.
    drive(1'b1, 16'h0001, 1'b0); step();
    drive(1'b0, 16'h0000, 1'b0); step();
    check("fill_issue0", 16'h0001, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 16'h2000 + 16'(i), 1'b0);
      step();
      if (i < 8)
        check($sformatf("fill_push%0d", i), 16'h0001, 1'b1, 1'b0, (i == 7),
              4'(i + 1), 1'b0, 1'b0);
      else
        check("fill_overflow", 16'h0001, 1'b1, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0);
    end
    drive(1'b0, 16'h0000, 1'b0); step();
    check("overflow_pulse_end", 16'h0001, 1'b1, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 16'h0000, 1'b1); step();
      check($sformatf("drain_issue%0d", k), 16'h2000 + 16'(k), 1'b0, (k == 7),
            1'b0, 4'(7 - k), 1'b0, 1'b0);
      drive(1'b0, 16'h0000, 1'b0); step();
      check($sformatf("drain_wait%0d", k), 16'h2000 + 16'(k), 1'b1, (k == 7),
            1'b0, 4'(7 - k), 1'b0, 1'b0);
    end

    // Three queued, done coincides with a push: back-to-back issue.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 16'h3000 + 16'(i), 1'b0); step();
    end
    check("b2b_queued3", 16'h2007, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
    drive(1'b1, 16'h3004, 1'b1); step();
    check("b2b_push_done", 16'h3001, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0); step();
    check("b2b_wait", 16'h3001, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      drive(1'b0, 16'h0000, 1'b1); step();
      check($sformatf("b2b_issue%0d", k), 16'h3000 + 16'(k), 1'b0, (k == 4),
            1'b0, 4'(4 - k), 1'b0, 1'b0);
      drive(1'b0, 16'h0000, 1'b0); step();
    end
    drive(1'b0, 16'h0000, 1'b1); step();
    check("b2b_to_idle", 16'h3004, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0); step();

    // Reset in WAIT with four queued and the tan second half pending.
    drive(1'b1, 16'h7ABC, 1'b0); step();
    drive(1'b1, 16'h0001, 1'b0); step();
    check("rst_tan_first", 16'h0ABC, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
    drive(1'b1, 16'h0002, 1'b0); step();
    drive(1'b1, 16'h0003, 1'b0); step();
    drive(1'b1, 16'h0004, 1'b0); step();
    check("rst_pre", 16'h0ABC, 1'b1, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0);
    reset = 1'b0;
    drive(1'b1, 16'h0005, 1'b1); step();
    check("rst_mid", 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b0, 16'h0000, 1'b0); step();
    check("rst_after", 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); step();
    check("rst_done_noissue", 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_quiet%0d", i), 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_issue.md
INSTRUCTION_ISSUE -- requirements
Module: instruction_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning instruction queue depth in entries (power of two, 2..16).
REQ-002 SHALL have port clock  in  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have port wr_en  in  1  push request for wr_packet.
REQ-005 SHALL have port wr_packet  in  16  instruction {opcode[15:12], x_addr[11:8], y_addr[7:4], z_addr[3:0]}.
REQ-006 SHALL have port done  in  1  single-cycle pulse from the CORDIC core: the current operation has completed.
REQ-007 SHALL have port InstructionPacket  out  16  packet presented to the Fetch stage.
REQ-008 SHALL have port stall  out  1  0 = Fetch captures InstructionPacket this edge; 1 = Fetch holds.
REQ-009 SHALL have ports full, empty  out  1 each  queue status, registered.
REQ-010 SHALL have port count  out  $clog2(DEPTH)+1  queued entries, registered.
REQ-011 SHALL have ports overflow, illegal  out  1 each  one-cycle pulses: rejected push; dropped opcode.

Function
REQ-012 SHALL implement a circular FIFO of DEPTH x 16 bits with wrapping read/write pointers.
REQ-013 SHALL accept a push when wr_en=1 and full=0, and SHALL reject it when full=1 (overflow=1 next cycle), even if a pop occurs in the same cycle.
REQ-014 SHALL support simultaneous push and pop; count is unchanged in that case.
REQ-015 SHALL run the FSM states IDLE, ISSUE, WAIT.
REQ-016 SHALL transition IDLE -> ISSUE when the queue is non-empty: pop the head and register it onto InstructionPacket, with stall=0 for exactly that one ISSUE cycle.
REQ-017 SHALL transition ISSUE -> WAIT unconditionally, with stall=1 throughout WAIT.
REQ-018 On done=1 in WAIT, SHALL go to ISSUE if a second half is pending or the queue is non-empty (back-to-back, no IDLE cycle), else to IDLE.
REQ-019 SHALL ignore done in IDLE and ISSUE.
REQ-020 SHALL forward legal opcodes 0-6 and 10 unchanged.
REQ-021 SHALL expand opcode 7 (tan) into two issues: opcode 0 with the original address fields, then, after its done, opcode 6 with the original address fields.
REQ-022 SHALL expand opcode 8 (tanh) into opcode 1, then opcode 6, in the same way as REQ-021.
REQ-023 SHALL not pop the queue for the second half of an expansion.
REQ-024 SHALL treat opcodes 9 and 11-15 as illegal: pop and discard them in one cycle with illegal=1, no issue, stall stays 1, and re-evaluate the queue in the next cycle.
REQ-025 SHALL hold InstructionPacket at its last issued value while stall=1.
REQ-026 Issue latency: a packet pushed into an empty queue in IDLE at edge N SHALL appear with stall=0 in cycle N+1.
REQ-027 SHALL generate no combinational path from any input to any output.

Reset
REQ-028 With reset=0 at an edge, SHALL set: FSM=IDLE, pointers=0, count=0, empty=1, full=0, stall=1, InstructionPacket=16'h0000, overflow=0, illegal=0, pending expansion cleared.
REQ-029 Reset mid-operation (ISSUE/WAIT, queue non-empty, expansion pending) SHALL discard all queued and pending work.
REQ-030 Pushes presented while reset=0 SHALL be ignored.

Verification
REQ-031 Push 16'h0005 into an idle, empty queue -> next cycle InstructionPacket=16'h0005 and stall=0 for one cycle; stall=1 until done; back to IDLE, empty=1.
REQ-032 Push 16'h7123 -> issue 16'h0123; after done, issue 16'h6123; count decrements only once.
REQ-033 Push 16'h9ABC then 16'h2010 -> illegal pulses once, and only 16'h2010 is issued.
REQ-034 Push 9 packets (DEPTH=8) while in WAIT -> count=8, full=1, 9th push gives overflow=1; the 8 queued packets then issue in order, one per done.
REQ-035 Queue holding 3 entries, done arriving in the same cycle as a push -> next ISSUE back-to-back with no IDLE cycle, and count stays consistent.
REQ-036 Assert reset in WAIT with 4 entries queued and a tan half pending -> all outputs at REQ-028 values; a later done causes no issue.
